// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the memory port arbiter
// Purpose: grant FSM state encoding, access owner encoding and the timeout
//          counter width helper used by mem_port_arbiter.
// Ports:   none (package).
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_e;

   // Width able to hold 0..timeout so the saturating timer never wraps.
   function automatic int timer_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle
// Purpose: groups the fetch port, data port, hazard stalls and memory port.
// Ports:   slave  = arbiter view (requests/memory response in, grants/memory request out)
//          master = requester + memory view (mirror of slave)
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_kill;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          stall_if;
   logic          stall_mem;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          bus_err;

   modport slave (
      input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, d_rdata, d_ack, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, d_rdata, d_ack, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter_perf_counters.sv
// rtl/mem_port_arbiter_perf_counters.sv - arbiter activity counters
// Purpose: three free-running 32-bit event counters, wrapping at 2^32.
// Ports:   clk, reset (sync, active-high)
//          i_fetch_done / i_data_done / i_conflict : one-cycle event strobes
//          o_perf_fetch / o_perf_data / o_perf_conflict : event counts
module arb_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_fetch_done,
   input  logic        i_data_done,
   input  logic        i_conflict,
   output logic [31:0] o_perf_fetch,
   output logic [31:0] o_perf_data,
   output logic [31:0] o_perf_conflict
);
   logic [31:0] r_fetch;
   logic [31:0] r_data;
   logic [31:0] r_conflict;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch    <= '0;
         r_data     <= '0;
         r_conflict <= '0;
      end else begin
         if (i_fetch_done) r_fetch    <= r_fetch + 32'd1;
         if (i_data_done)  r_data     <= r_data + 32'd1;
         if (i_conflict)   r_conflict <= r_conflict + 32'd1;
      end
   end

   assign o_perf_fetch    = r_fetch;
   assign o_perf_data     = r_data;
   assign o_perf_conflict = r_conflict;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
// Purpose: registered grant FSM (IDLE/BUSY_I/BUSY_D/DONE), data port has fixed
//          priority, timeout abort with bus_err, fetch kill support.
// Ports:   clk, reset (sync, active-high)
//          bus (mem_port_arbiter_if.slave): fetch port, data port, stalls, memory port
//          perf_fetch/perf_data/perf_conflict: only when ARB_PERF_CNT_EN is defined
// Config:  ARB_PERF_CNT_EN adds the activity counters; FSM is identical either way.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetch,
   output logic [31:0]         perf_data,
   output logic [31:0]         perf_conflict
`endif
);
   localparam int TW = timer_width(TIMEOUT);

   arb_state_e    r_state;
   arb_state_e    w_next;
   arb_owner_e    r_owner;
   logic          r_we;
   logic          r_kill;
   logic          r_abort;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic [TW-1:0] r_timer;

   logic w_busy;
   logic w_done;
   logic w_grant_d;
   logic w_grant_i;
   logic w_timeout;

   assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
   assign w_done    = (r_state == DONE);
   assign w_grant_d = (r_state == IDLE) && bus.d_req;
   // if_kill in IDLE only blocks the grant for the current cycle.
   assign w_grant_i = (r_state == IDLE) && !bus.d_req && bus.if_req && !bus.if_kill;
   // A late mem_ack in the final allowed cycle still wins over the abort.
   assign w_timeout = w_busy && !bus.mem_ack && (r_timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_d)      w_next = BUSY_D;
            else if (w_grant_i) w_next = BUSY_I;
         end
         BUSY_I, BUSY_D: begin
            if (bus.mem_ack || w_timeout) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner <= OWN_I;
         r_we    <= 1'b0;
         r_kill  <= 1'b0;
         r_abort <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_timer <= '0;
      end else begin
         if (w_grant_d) begin
            r_owner <= OWN_D;
            r_we    <= bus.d_we;
            r_addr  <= bus.d_addr;
            r_wdata <= bus.d_wdata;
            r_timer <= '0;
            r_abort <= 1'b0;
         end else if (w_grant_i) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= bus.if_addr;
            r_timer <= '0;
            r_abort <= 1'b0;
         end

         if (w_busy) begin
            if (bus.mem_ack) begin
               r_rdata <= bus.mem_rdata;
            end else if (w_timeout) begin
               r_rdata <= '0;
               r_abort <= 1'b1;
            end else if (r_timer != TW'(TIMEOUT)) begin
               r_timer <= r_timer + TW'(1);
            end
            // The killed fetch still finishes on memory; only its ack is hidden.
            if ((r_state == BUSY_I) && bus.if_kill) r_kill <= 1'b1;
         end

         if (w_done) begin
            r_kill  <= 1'b0;
            r_abort <= 1'b0;
         end
      end
   end

   assign bus.mem_req   = w_busy;
   assign bus.mem_we    = w_busy && r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.if_ack    = w_done && (r_owner == OWN_I) && !r_kill;
   assign bus.d_ack     = w_done && (r_owner == OWN_D);
   assign bus.if_rdata  = r_rdata;
   assign bus.d_rdata   = r_rdata;
   assign bus.bus_err   = w_done && r_abort;
   assign bus.stall_if  = bus.if_req && !bus.if_ack;
   assign bus.stall_mem = bus.d_req && !bus.d_ack;

`ifdef ARB_PERF_CNT_EN
   arb_perf_counters u_perf (
      .clk             (clk),
      .reset           (reset),
      .i_fetch_done    (w_done && (r_owner == OWN_I)),
      .i_data_done     (w_done && (r_owner == OWN_D)),
      .i_conflict      ((r_state == IDLE) && bus.if_req && bus.d_req),
      .o_perf_fetch    (perf_fetch),
      .o_perf_data     (perf_data),
      .o_perf_conflict (perf_conflict)
   );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_data;
   logic [31:0] perf_conflict;
`endif

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_fetch    (perf_fetch),
      .perf_data     (perf_data),
      .perf_conflict (perf_conflict)
`endif
   );

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   txn_t        mem_log[$];
   logic [31:0] mem_model [0:255];
   int          ack_delay = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory model: acks ack_delay cycles after mem_req rises (-1 = never).
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (bus.mem_req) begin
            if (cnt == ack_delay) begin
               txn_t t;
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_model[bus.mem_addr[9:2]];
               t.we = bus.mem_we; t.addr = bus.mem_addr; t.wdata = bus.mem_wdata;
               mem_log.push_back(t);
               if (bus.mem_we) mem_model[bus.mem_addr[9:2]] = bus.mem_wdata;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Ack monitor: every completion pulse is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.bus_err) chk("bus_err_with_ack", 64'(bus.if_ack | bus.d_ack), 64'd1);
            if (bus.if_ack || bus.d_ack) begin
               chk("dual_ack", 64'(bus.if_ack & bus.d_ack), 64'd0);
               chk("ack_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("ack_owner", 64'(bus.d_ack), 64'(e.is_d));
                  chk("ack_rdata", 64'(e.is_d ? bus.d_rdata : bus.if_rdata), 64'(e.rdata));
                  chk("ack_bus_err", 64'(bus.bus_err), 64'(e.err));
                  chk("mem_req_at_ack", 64'(bus.mem_req), 64'd0);
               end
            end
         end
      end
   end

   task automatic wait_acks(input bit pi_in, input bit pd_in, output int cyc);
      bit pi, pd;
      pi = pi_in; pd = pd_in; cyc = 0;
      while ((pi || pd) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.if_ack) pi = 1'b0;
         if (bus.d_ack)  pd = 1'b0;
         @(posedge clk);
         #1;
         if (!pi) bus.if_req = 1'b0;
         if (!pd) bus.d_req  = 1'b0;
      end
      chk("acks_within_budget", 64'(pi || pd), 64'd0);
   endtask

   task automatic issue(input bit fi, input logic [31:0] fa, input bit di, input bit dwe,
                        input logic [31:0] da, input logic [31:0] dwd, input int delay,
                        output int cyc);
      exp_t e;
      @(posedge clk);
      #1;
      ack_delay = delay;
      if (di) begin
         e.is_d = 1'b1; e.err = (delay < 0);
         e.rdata = (delay < 0) ? 32'd0 : mem_model[da[9:2]];
         sb.push_back(e);
         bus.d_req = 1'b1; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
      end
      if (fi) begin
         e.is_d = 1'b0; e.err = (delay < 0);
         e.rdata = (delay < 0) ? 32'd0 : mem_model[fa[9:2]];
         sb.push_back(e);
         bus.if_req = 1'b1; bus.if_addr = fa;
      end
      wait_acks(fi, di, cyc);
   endtask

   task automatic chk_log(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      txn_t t;
      chk({tag, "_present"}, 64'(mem_log.size() != 0), 64'd1);
      if (mem_log.size() != 0) begin
         t = mem_log.pop_front();
         chk({tag, "_we"}, 64'(t.we), 64'(we));
         chk({tag, "_addr"}, 64'(t.addr), 64'(addr));
         if (we) chk({tag, "_wdata"}, 64'(t.wdata), 64'(wdata));
      end
   endtask

   initial begin
      int   cyc;
      exp_t e;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'hA000_0000 + 32'(i);
      mem_model[16] = 32'h0050_0093;
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_acks", 64'({bus.if_ack, bus.d_ack, bus.bus_err}), 64'd0);
      chk("rst_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
      chk("rst_stalls", 64'({bus.stall_if, bus.stall_mem}), 64'd0);

      // Lone fetch, ack two cycles after mem_req rises
      issue(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2, cyc);
      chk("fetch_latency", 64'(cyc), 64'd5);
      chk_log("fetch_mem", 1'b0, 32'h40, 32'h0);

      // Minimum-latency load
      issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 0, cyc);
      chk("load_min_latency", 64'(cyc), 64'd3);
      chk_log("load_mem", 1'b0, 32'h20, 32'h0);

      // if_kill in IDLE blocks the grant for that cycle only
      @(posedge clk);
      #1;
      ack_delay = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h44; bus.if_kill = 1'b1;
      e.is_d = 1'b0; e.rdata = mem_model[17]; e.err = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.if_kill = 1'b0;
      @(negedge clk);
      chk("idle_kill_blocks", 64'(bus.mem_req), 64'd0);
      chk("idle_kill_stall_if", 64'(bus.stall_if), 64'd1);
      wait_acks(1'b1, 1'b0, cyc);
      chk("idle_kill_then_grant", 64'(cyc), 64'd2);
      chk_log("idle_kill_mem", 1'b0, 32'h44, 32'h0);

      // Simultaneous requests: store served first, then the fetch
      issue(1'b1, 32'h48, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, cyc);
      chk("conflict_cycles", 64'(cyc), 64'd6);
      chk_log("conflict_first", 1'b1, 32'h100, 32'hDEAD_BEEF);
      chk_log("conflict_second", 1'b0, 32'h48, 32'h0);

      // Kill one cycle into BUSY_I: memory access completes, no if_ack
      @(posedge clk);
      #1;
      ack_delay = 3;
      bus.if_req = 1'b1; bus.if_addr = 32'h88;
      @(posedge clk);
      #1;
      bus.if_kill = 1'b1; bus.if_req = 1'b0;
      @(posedge clk);
      #1 bus.if_kill = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("kill_idle_mem_req", 64'(bus.mem_req), 64'd0);
      chk("kill_stall_if", 64'(bus.stall_if), 64'd0);
      chk_log("kill_mem", 1'b0, 32'h88, 32'h0);

      // Data request after the kill is granted normally
      issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 1, cyc);
      chk("post_kill_load_cycles", 64'(cyc), 64'd4);
      chk_log("post_kill_mem", 1'b0, 32'h80, 32'h0);

      // No mem_ack: abort after 16 BUSY cycles, ack with rdata 0 and bus_err
      issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, -1, cyc);
      chk("timeout_cycles", 64'(cyc), 64'd18);
      chk("timeout_no_mem_txn", 64'(mem_log.size()), 64'd0);

`ifdef ARB_PERF_CNT_EN
      chk("perf_fetch", 64'(perf_fetch), 64'd4);
      chk("perf_data", 64'(perf_data), 64'd4);
      chk("perf_conflict", 64'(perf_conflict), 64'd1);
`endif

      // Reset in the middle of BUSY_D
      @(posedge clk);
      #1;
      ack_delay = -1;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h180; bus.d_wdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("busy_d_mem_req", 64'(bus.mem_req), 64'd1);
      chk("busy_d_mem_we", 64'(bus.mem_we), 64'd1);
      chk("busy_d_mem_addr", 64'(bus.mem_addr), 64'h180);
      chk("busy_d_stall_mem", 64'(bus.stall_mem), 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_mid_d_ack", 64'(bus.d_ack), 64'd0);
      chk("rst_mid_stall_mem", 64'(bus.stall_mem), 64'd1);
      @(posedge clk);
      #1 bus.d_req = 1'b0;
      @(negedge clk);
      chk("rst_mid_stall_drop", 64'(bus.stall_mem), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_mem_req", 64'(bus.mem_req), 64'd0);
`ifdef ARB_PERF_CNT_EN
      chk("perf_cleared", 64'(perf_fetch | perf_data | perf_conflict), 64'd0);
`endif

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
